// File: rtl/dram_arbiter_if.sv
// Requester-side bus between one RAM client (CPU data port or bench loader) and dram_arbiter.
// The master drives the request; the slave returns read data and waitrequest.
interface dram_arbiter_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between two requesters.
// Partial byte-enabled writes become a read-modify-write: fetch, bubble, merged write.
module dram_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    dram_arbiter_if.slave     m0,
    dram_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata
);
    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] merge_q, merge_d;

    logic              req0, req1, win;
    logic [ADDR_W-1:0] win_addr, own_addr;
    logic              win_wr;
    logic [BE_W-1:0]   win_be, own_be;
    logic [DATA_W-1:0] win_wd, own_wd, merged;
    logic [1:0]        wait_c;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;
    // On a tie the requester that did not complete last goes next.
    assign win  = (req0 && req1) ? ~last_q : req1;

    assign win_addr = win ? m1.address    : m0.address;
    assign win_wr   = win ? m1.write      : m0.write;
    assign win_be   = win ? m1.byteenable : m0.byteenable;
    assign win_wd   = win ? m1.writedata  : m0.writedata;

    assign own_addr = owner_q ? m1.address    : m0.address;
    assign own_be   = owner_q ? m1.byteenable : m0.byteenable;
    assign own_wd   = owner_q ? m1.writedata  : m0.writedata;

    always_comb begin
        merged = merge_q;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (own_be[i]) merged[8*i +: 8] = own_wd[8*i +: 8];
        end
    end

    assign m0.readdata    = ram_readdata;
    assign m1.readdata    = ram_readdata;
    assign m0.waitrequest = wait_c[0];
    assign m1.waitrequest = wait_c[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            merge_q <= merge_d;
        end
    end

    // Reset gates every RAM strobe, which also aborts an in-flight read-modify-write.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        owner_d       = owner_q;
        merge_d       = merge_q;
        ram_read      = 1'b0;
        ram_write     = 1'b0;
        ram_address   = '0;
        ram_writedata = '0;
        wait_c        = 2'b11;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        if (win_wr && (win_be == '1)) begin
                            ram_write     = 1'b1;
                            ram_address   = win_addr;
                            ram_writedata = win_wd;
                            wait_c[win]   = 1'b0;
                            last_d        = win;
                        end else if (win_wr && (win_be == '0)) begin
                            wait_c[win] = 1'b0;
                            last_d      = win;
                        end else if (win_wr) begin
                            ram_read    = 1'b1;
                            ram_address = win_addr;
                            merge_d     = ram_readdata;
                            owner_d     = win;
                            state_d     = RMW_RD;
                        end else begin
                            ram_read    = 1'b1;
                            ram_address = win_addr;
                            wait_c[win] = 1'b0;
                            last_d      = win;
                        end
                    end
                end
                RMW_RD: state_d = RMW_WR;
                RMW_WR: begin
                    ram_write       = 1'b1;
                    ram_address     = own_addr;
                    ram_writedata   = merged;
                    wait_c[owner_q] = 1'b0;
                    last_d          = owner_q;
                    state_d         = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule
